// File: rtl/multicycle_control.sv
// multicycle_control: IDLE/DECODE/EXEC/MEM/WB controller that sequences
// one instruction at a time and drives datapath selects and strobes.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   instr_valid  requester presents an instruction
//   instr_ready  controller is in IDLE and can accept
//   opcode[5:0]  instruction opcode, latched on accept
//   Zero         ALU zero flag (drives PCSrc for beq)
//   Regsel       1 = write register is rd
//   ALUsel       1 = ALU B operand is sign-extended immediate
//   MemToRegSel  1 = write-back data is memory read data
//   ALUOp[1:0]   00 add, 01 subtract, 10 decode FuncCode
//   RegWrite     register file write strobe (WB only)
//   MemWrite     data memory write strobe (sw MEM only)
//   MemRead      data memory read strobe (lw MEM only)
//   PCSrc        branch taken select (MULTICYCLE_BRANCH_EN only)
//   done         pulses in the final state of a legal instruction
//   err          pulses in DECODE for an unrecognised opcode
//
// Build option: define MULTICYCLE_BRANCH_EN to add beq (opcode 000100)
// and the PCSrc output; otherwise 000100 decodes as illegal.

module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [5:0] opcode,
    input  logic       Zero,
    output logic       Regsel,
    output logic       ALUsel,
    output logic       MemToRegSel,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemRead,
`ifdef MULTICYCLE_BRANCH_EN
    output logic       PCSrc,
`endif
    output logic       done,
    output logic       err
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MULTICYCLE_BRANCH_EN
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`endif

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILL,
        CLS_RTYPE,
        CLS_LW,
        CLS_SW,
        CLS_ADDI,
        CLS_BEQ
    } cls_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    cls_t       cls;
    logic       accept;

    assign instr_ready = (state_q == IDLE);
    assign accept      = instr_valid && instr_ready;

    // Classify the latched opcode; everything downstream keys off cls.
    always_comb begin
        cls = CLS_ILL;
        case (op_q)
            OP_RTYPE: cls = CLS_RTYPE;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_ADDI:  cls = CLS_ADDI;
`ifdef MULTICYCLE_BRANCH_EN
            OP_BEQ:   cls = CLS_BEQ;
`endif
            default:  cls = CLS_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (cls == CLS_ILL) begin
                    state_d = IDLE;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (cls)
                    CLS_RTYPE, CLS_ADDI: state_d = WB;
                    CLS_LW, CLS_SW:      state_d = MEM;
                    default:             state_d = IDLE;
                endcase
            end
            MEM: begin
                if (cls == CLS_LW) begin
                    state_d = WB;
                end else begin
                    state_d = IDLE;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Selects are held for the whole instruction so the datapath sees
    // stable muxes from DECODE through the last state; IDLE drives 0.
    always_comb begin
        Regsel      = 1'b0;
        ALUsel      = 1'b0;
        MemToRegSel = 1'b0;
        ALUOp       = ALU_ADD;
        if (state_q != IDLE) begin
            case (cls)
                CLS_RTYPE: begin
                    Regsel = 1'b1;
                    ALUOp  = ALU_FUNC;
                end
                CLS_LW: begin
                    ALUsel      = 1'b1;
                    MemToRegSel = 1'b1;
                end
                CLS_SW: begin
                    ALUsel = 1'b1;
                end
                CLS_ADDI: begin
                    ALUsel = 1'b1;
                end
                CLS_BEQ: begin
                    ALUOp = ALU_SUB;
                end
                default: begin
                    ALUOp = ALU_ADD;
                end
            endcase
        end
    end

    always_comb begin
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            DECODE: begin
                err = (cls == CLS_ILL);
            end
            EXEC: begin
                done = (cls == CLS_BEQ);
            end
            MEM: begin
                MemRead  = (cls == CLS_LW);
                MemWrite = (cls == CLS_SW);
                done     = (cls == CLS_SW);
            end
            WB: begin
                RegWrite = 1'b1;
                done     = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

`ifdef MULTICYCLE_BRANCH_EN
    assign PCSrc = (state_q == EXEC) && (cls == CLS_BEQ) && Zero;
`else
    // Zero only feeds the branch path, absent in this build.
    logic unused_zero;
    assign unused_zero = Zero;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction output traces
// are queued on accept and compared cycle by cycle against the DUT.
`timescale 1ns/1ps
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       Zero = 1'b0;
    logic       instr_ready;
    logic       Regsel;
    logic       ALUsel;
    logic       MemToRegSel;
    logic [1:0] ALUOp;
    logic       RegWrite;
    logic       MemWrite;
    logic       MemRead;
    logic       PCSrc;
    logic       done;
    logic       err;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .Zero        (Zero),
        .Regsel      (Regsel),
        .ALUsel      (ALUsel),
        .MemToRegSel (MemToRegSel),
        .ALUOp       (ALUOp),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
`ifdef MULTICYCLE_BRANCH_EN
        .PCSrc       (PCSrc),
`endif
        .done        (done),
        .err         (err)
    );

`ifndef MULTICYCLE_BRANCH_EN
    assign PCSrc = 1'b0;
`endif

    always #5 clk = ~clk;

    // {rdy, Regsel, ALUsel, MemToRegSel, ALUOp, RegWrite,
    //  MemWrite, MemRead, done, err, PCSrc}
    logic [11:0] obs;
    assign obs = {instr_ready, Regsel, ALUsel, MemToRegSel, ALUOp,
                  RegWrite, MemWrite, MemRead, done, err, PCSrc};

    typedef struct {
        logic [11:0] v;
        logic [5:0]  op;
        int          k;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
    } req_t;

    exp_t exp_q[$];
    req_t pend_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic rst_req = 1'b1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    function automatic logic [11:0] mk(
        input logic rdy, input logic rs, input logic as, input logic m2r,
        input logic [1:0] aop, input logic rw, input logic mw,
        input logic mr, input logic dn, input logic er, input logic pc);
        return {rdy, rs, as, m2r, aop, rw, mw, mr, dn, er, pc};
    endfunction

    // Expected per-cycle outputs of one instruction, DECODE onward.
    task automatic push_trace(input logic [5:0] op, input logic z);
        logic       rs, as, m2r;
        logic [1:0] aop;
        int         len;
        int         kind;
        exp_t       e;
        rs = 0; as = 0; m2r = 0; aop = 2'b00; len = 1; kind = 4;
        case (op)
            6'b000000: begin rs = 1; aop = 2'b10; len = 3; kind = 0; end
            6'b001000: begin as = 1; len = 3; kind = 0; end
            6'b100011: begin as = 1; m2r = 1; len = 4; kind = 1; end
            6'b101011: begin as = 1; len = 3; kind = 2; end
`ifdef MULTICYCLE_BRANCH_EN
            6'b000100: begin aop = 2'b01; len = 2; kind = 3; end
`endif
            default:   begin len = 1; kind = 4; end
        endcase
        for (int k = 1; k <= len; k++) begin
            e.op = op;
            e.k  = k;
            e.v  = mk(1'b0, rs, as, m2r, aop,
                      (kind <= 1) && (k == len),
                      (kind == 2) && (k == 3),
                      (kind == 1) && (k == 3),
                      (kind != 4) && (k == len),
                      (kind == 4),
                      (kind == 3) && (k == 2) && z);
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic z);
        req_t r;
        r.op = op;
        r.z  = z;
        pend_q.push_back(r);
    endtask

    // One cycle: compare current outputs, then drive next inputs.
    task automatic tick();
        exp_t  e;
        logic  was_idle;
        string tag;
        @(negedge clk);
        was_idle = (exp_q.size() == 0);
        if (was_idle) begin
            e.v = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
            tag = "idle";
        end else begin
            e = exp_q.pop_front();
            tag = $sformatf("op%b_c%0d", e.op, e.k);
        end
        check(tag, {20'd0, obs}, {20'd0, e.v});
        reset = rst_req;
        if (rst_req) begin
            exp_q.delete();
        end
        if (pend_q.size() != 0) begin
            instr_valid = 1'b1;
            opcode = pend_q[0].op;
            if (was_idle && !rst_req) begin
                Zero = pend_q[0].z;
                push_trace(pend_q[0].op, pend_q[0].z);
                void'(pend_q.pop_front());
            end
        end else begin
            instr_valid = 1'b0;
            opcode = 6'($urandom_range(0, 63));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    logic [5:0] pool [6];

    initial begin
        pool = '{6'b000000, 6'b100011, 6'b101011,
                 6'b001000, 6'b000100, 6'b010101};
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;

        issue(6'b100011, 1'b0);
        run(7);
        issue(6'b101011, 1'b1);
        run(6);
        issue(6'b000000, 1'b0);
        issue(6'b001000, 1'b1);
        run(10);
        issue(6'b111111, 1'b0);
        run(4);
        issue(6'b000100, 1'b1);
        issue(6'b000100, 1'b0);
        run(8);

        // Abort lw in MEM, with a new request pending during reset.
        issue(6'b100011, 1'b0);
        run(3);
        issue(6'b001000, 1'b0);
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;
        run(6);

        for (int i = 0; i < 8; i++) begin
            issue(pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
        end
        run(40);

        check("drained", pend_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
